// File: rtl/tb_dmem_irq_if.sv
// Bus bundle between the CPU-side bench driver and the data-memory/interrupt model.
// Covers the data port, the interrupt device port and the write-trace stream.
interface tb_dmem_irq_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;
  logic        oob_err;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [15:0] trace_drops;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
           macroscopic_pc, m_int_addr, m_int_byteen, trace_ready,
    input  m_data_rdata, interrupt, oob_err, trace_valid,
           trace_pc, trace_addr, trace_data, trace_drops
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr,
           macroscopic_pc, m_int_addr, m_int_byteen, trace_ready,
    output m_data_rdata, interrupt, oob_err, trace_valid,
           trace_pc, trace_addr, trace_data, trace_drops
  );
endinterface

// File: rtl/tb_dmem_irq.sv
// Data memory with byte-lane writes, configurable read latency, write-trace FIFO
// and a one-shot interrupt generator for the pipelined MIPS benches.
module tb_dmem_irq #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          RD_LAT      = 0,
  parameter int          TRACE_DEPTH = 8,
  parameter logic [31:0] IRQ_PC      = 32'h0000_3010,
  parameter logic [31:0] IRQ_ADDR    = 32'h0000_7F20
) (
  input  logic         clk,
  input  logic         reset,
  tb_dmem_irq_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {ARMED, ASSERTED, DONE} irq_state_t;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [29:0]      word_off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [31:0]      merged;
  logic             wr_req;
  logic             wr_ok;

  // Word offset from the base; BASE_ADDR is word aligned so its low bits never matter.
  assign word_off = bus.m_data_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (bus.m_data_addr >= BASE_ADDR) && ({2'b00, word_off} < 32'(DEPTH_WORDS));
  assign idx      = word_off[IDX_W-1:0];
  assign rd_word  = in_range ? mem[idx] : 32'h0;
  assign wr_req   = |bus.m_data_byteen;
  assign wr_ok    = wr_req && in_range;

  always_comb begin
    merged = rd_word;
    for (int k = 0; k < 4; k++) begin
      if (bus.m_data_byteen[k]) merged[8*k +: 8] = bus.m_data_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (wr_ok) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.oob_err <= 1'b0;
    else       bus.oob_err <= wr_req && !in_range;
  end

  // The read value is captured at address time, so stages carry read-before-write data.
  generate
    if (RD_LAT == 0) begin : g_comb_read
      assign bus.m_data_rdata = rd_word;
    end else begin : g_pipe_read
      logic [31:0] pipe [RD_LAT];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < RD_LAT; s++) pipe[s] <= 32'h0;
        end else begin
          pipe[0] <= rd_word;
          for (int s = 1; s < RD_LAT; s++) pipe[s] <= pipe[s-1];
        end
      end
      assign bus.m_data_rdata = pipe[RD_LAT-1];
    end
  endgenerate

  logic [31:0]      fifo_pc   [TRACE_DEPTH];
  logic [31:0]      fifo_addr [TRACE_DEPTH];
  logic [31:0]      fifo_data [TRACE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, pop, do_push, drop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop     = !empty && bus.trace_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = wr_ok && (!full || pop);
  assign drop    = wr_ok && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        fifo_pc[i]   <= 32'h0;
        fifo_addr[i] <= 32'h0;
        fifo_data[i] <= 32'h0;
      end
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      bus.trace_drops <= 16'h0;
    end else begin
      if (do_push) begin
        fifo_pc[wr_ptr]   <= bus.m_inst_addr;
        fifo_addr[wr_ptr] <= bus.m_data_addr & ~32'h3;
        fifo_data[wr_ptr] <= merged;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && bus.trace_drops != 16'hFFFF) bus.trace_drops <= bus.trace_drops + 16'h1;
    end
  end

  assign bus.trace_valid = !empty;
  assign bus.trace_pc    = fifo_pc[rd_ptr];
  assign bus.trace_addr  = fifo_addr[rd_ptr];
  assign bus.trace_data  = fifo_data[rd_ptr];

  irq_state_t state, next_state;
  logic       ack;

  assign ack = |bus.m_int_byteen && ((bus.m_int_addr & ~32'h3) == IRQ_ADDR);

  always_ff @(posedge clk) begin
    if (reset) state <= ARMED;
    else       state <= next_state;
  end

  // DONE has no exit, so the interrupt fires at most once per reset.
  always_comb begin
    next_state    = state;
    bus.interrupt = 1'b0;
    case (state)
      ARMED:    if (bus.macroscopic_pc == IRQ_PC) next_state = ASSERTED;
      ASSERTED: begin
        bus.interrupt = 1'b1;
        if (ack) next_state = DONE;
      end
      DONE:     next_state = DONE;
      default:  next_state = ARMED;
    endcase
  end
endmodule

// File: tb/tb_tb_dmem_irq.sv
// Directed self-checking bench for tb_dmem_irq: one default instance (combinational
// read) and one with a two-stage read pipeline.
module tb_tb_dmem_irq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tb_dmem_irq_if bi0();
  tb_dmem_irq_if bi2();

  tb_dmem_irq #(.DEPTH_WORDS(4096), .RD_LAT(0), .TRACE_DEPTH(8)) dut0 (
    .clk(clk), .reset(reset), .bus(bi0)
  );
  tb_dmem_irq #(.DEPTH_WORDS(64), .RD_LAT(2), .TRACE_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bi2)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bi0.m_data_addr = 32'h0; bi0.m_data_wdata = 32'h0; bi0.m_data_byteen = 4'h0;
    bi0.m_inst_addr = 32'h0; bi0.macroscopic_pc = 32'h0; bi0.m_int_addr = 32'h0;
    bi0.m_int_byteen = 4'h0; bi0.trace_ready = 1'b0;
    bi2.m_data_addr = 32'h0; bi2.m_data_wdata = 32'h0; bi2.m_data_byteen = 4'h0;
    bi2.m_inst_addr = 32'h0; bi2.macroscopic_pc = 32'h0; bi2.m_int_addr = 32'h0;
    bi2.m_int_byteen = 4'h0; bi2.trace_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cyc(); cyc();
    #1;
    checks++; if (bi0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %0h expected 0", bi0.interrupt); end
    checks++; if (bi0.oob_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_oob: got %0h expected 0", bi0.oob_err); end
    checks++; if (bi0.trace_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %0h expected 0", bi0.trace_valid); end
    checks++; if (bi0.trace_drops !== 16'h0) begin errors++; $display("[TB] FAIL reset_drops: got %h expected 0000", bi0.trace_drops); end
    checks++; if ({bi0.trace_pc, bi0.trace_addr, bi0.trace_data} !== 96'h0) begin errors++; $display("[TB] FAIL reset_tdata: got %h %h %h expected zeros", bi0.trace_pc, bi0.trace_addr, bi0.trace_data); end
    checks++; if (bi0.m_data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata0: got %h expected 00000000", bi0.m_data_rdata); end
    checks++; if (bi2.m_data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata2: got %h expected 00000000", bi2.m_data_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_byte_write();
    bi0.m_data_addr = 32'h100; bi0.m_data_wdata = 32'hAABBCCDD;
    bi0.m_data_byteen = 4'b0010; bi0.m_inst_addr = 32'h3000;
    cyc();
    bi0.m_data_addr = 32'h102; bi0.m_data_wdata = 32'h11223344;
    bi0.m_data_byteen = 4'b1001; bi0.m_inst_addr = 32'h3004;
    #1;
    checks++; if (bi0.m_data_rdata !== 32'h0000CC00) begin errors++; $display("[TB] FAIL lane_read: got %h expected 0000CC00", bi0.m_data_rdata); end
    checks++; if (bi0.trace_valid !== 1'b1) begin errors++; $display("[TB] FAIL trace_valid1: got %0h expected 1", bi0.trace_valid); end
    checks++; if ({bi0.trace_pc, bi0.trace_addr, bi0.trace_data} !== {32'h3000, 32'h100, 32'h0000CC00}) begin errors++; $display("[TB] FAIL trace_entry1: got %h %h %h expected 00003000 00000100 0000cc00", bi0.trace_pc, bi0.trace_addr, bi0.trace_data); end
    cyc();
    bi0.m_data_byteen = 4'h0; bi0.m_data_addr = 32'h100; bi0.trace_ready = 1'b1;
    #1;
    checks++; if (bi0.m_data_rdata !== 32'h1100CC44) begin errors++; $display("[TB] FAIL merge_read: got %h expected 1100CC44", bi0.m_data_rdata); end
    cyc();
    #1;
    checks++; if ({bi0.trace_pc, bi0.trace_addr, bi0.trace_data} !== {32'h3004, 32'h100, 32'h1100CC44}) begin errors++; $display("[TB] FAIL trace_entry2: got %h %h %h expected 00003004 00000100 1100cc44", bi0.trace_pc, bi0.trace_addr, bi0.trace_data); end
    cyc();
    bi0.trace_ready = 1'b0;
    #1;
    checks++; if (bi0.trace_valid !== 1'b0) begin errors++; $display("[TB] FAIL trace_drained: got %0h expected 0", bi0.trace_valid); end
  endtask

  task automatic test_range();
    bi0.m_data_addr = 32'h3FFC; bi0.m_data_wdata = 32'hCAFEF00D;
    bi0.m_data_byteen = 4'hF; bi0.m_inst_addr = 32'h3100;
    cyc();
    bi0.m_data_byteen = 4'h0; bi0.trace_ready = 1'b1;
    #1;
    checks++; if (bi0.m_data_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL last_word: got %h expected CAFEF00D", bi0.m_data_rdata); end
    checks++; if (bi0.oob_err !== 1'b0) begin errors++; $display("[TB] FAIL last_word_oob: got %0h expected 0", bi0.oob_err); end
    checks++; if (bi0.trace_addr !== 32'h3FFC) begin errors++; $display("[TB] FAIL last_word_trace: got %h expected 00003FFC", bi0.trace_addr); end
    cyc();
    bi0.trace_ready = 1'b0;
    bi0.m_data_addr = 32'h4000; bi0.m_data_wdata = 32'hDEADBEEF; bi0.m_data_byteen = 4'hF;
    #1;
    checks++; if (bi0.m_data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL oob_read: got %h expected 00000000", bi0.m_data_rdata); end
    cyc();
    bi0.m_data_byteen = 4'h0; bi0.m_data_addr = 32'h0;
    #1;
    checks++; if (bi0.oob_err !== 1'b1) begin errors++; $display("[TB] FAIL oob_pulse: got %0h expected 1", bi0.oob_err); end
    checks++; if (bi0.trace_valid !== 1'b0) begin errors++; $display("[TB] FAIL oob_no_trace: got %0h expected 0", bi0.trace_valid); end
    checks++; if (bi0.m_data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL oob_alias: got %h expected 00000000", bi0.m_data_rdata); end
    cyc();
    checks++; if (bi0.oob_err !== 1'b0) begin errors++; $display("[TB] FAIL oob_one_cycle: got %0h expected 0", bi0.oob_err); end
  endtask

  task automatic test_latency();
    bi2.m_data_addr = 32'h4; bi2.m_data_wdata = 32'h12345678; bi2.m_data_byteen = 4'hF;
    cyc();
    bi2.m_data_byteen = 4'h0;
    cyc();
    bi2.m_data_addr = 32'h8;
    #1;
    checks++; if (bi2.m_data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL lat_rbw: got %h expected 00000000", bi2.m_data_rdata); end
    cyc();
    checks++; if (bi2.m_data_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL lat_data: got %h expected 12345678", bi2.m_data_rdata); end
    cyc();
    checks++; if (bi2.m_data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL lat_next: got %h expected 00000000", bi2.m_data_rdata); end
  endtask

  task automatic test_trace_overflow();
    bi0.trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bi0.m_data_addr = 32'h200 + 32'(4 * i); bi0.m_data_wdata = 32'(i + 1);
      bi0.m_data_byteen = 4'hF; bi0.m_inst_addr = 32'h3200 + 32'(4 * i);
      cyc();
    end
    bi0.m_data_addr = 32'h228; bi0.m_data_wdata = 32'd11; bi0.m_inst_addr = 32'h3228;
    bi0.trace_ready = 1'b1;
    #1;
    checks++; if (bi0.trace_drops !== 16'd2) begin errors++; $display("[TB] FAIL drops_full: got %0d expected 2", bi0.trace_drops); end
    checks++; if (bi0.trace_data !== 32'd1) begin errors++; $display("[TB] FAIL head_first: got %h expected 00000001", bi0.trace_data); end
    cyc();
    bi0.m_data_byteen = 4'h0;
    #1;
    checks++; if (bi0.trace_drops !== 16'd2) begin errors++; $display("[TB] FAIL drops_pushpop: got %0d expected 2", bi0.trace_drops); end
    for (int i = 0; i < 8; i++) begin
      int d;
      d = (i < 7) ? i + 2 : 11;
      checks++; if ({bi0.trace_valid, bi0.trace_data, bi0.trace_pc} !== {1'b1, 32'(d), 32'h3200 + 32'(4 * (d - 1))}) begin errors++; $display("[TB] FAIL drain_%0d: got v=%0h %h %h expected v=1 %h %h", i, bi0.trace_valid, bi0.trace_data, bi0.trace_pc, 32'(d), 32'h3200 + 32'(4 * (d - 1))); end
      cyc();
    end
    bi0.trace_ready = 1'b0;
    #1;
    checks++; if (bi0.trace_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %0h expected 0", bi0.trace_valid); end
  endtask

  task automatic test_irq();
    bi0.m_int_addr = 32'h7F20; bi0.m_int_byteen = 4'hF;
    cyc();
    bi0.m_int_byteen = 4'h0; bi0.macroscopic_pc = 32'h3010;
    #1;
    checks++; if (bi0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL irq_early: got %0h expected 0", bi0.interrupt); end
    cyc();
    bi0.macroscopic_pc = 32'h3014;
    #1;
    checks++; if (bi0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL irq_rise: got %0h expected 1", bi0.interrupt); end
    bi0.m_int_addr = 32'h7F24; bi0.m_int_byteen = 4'hF;
    cyc();
    bi0.m_int_addr = 32'h7F22; bi0.m_int_byteen = 4'h0;
    cyc();
    checks++; if (bi0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL irq_held: got %0h expected 1", bi0.interrupt); end
    bi0.m_int_addr = 32'h7F23; bi0.m_int_byteen = 4'h1;
    #1;
    checks++; if (bi0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL irq_ack_cycle: got %0h expected 1", bi0.interrupt); end
    cyc();
    bi0.m_int_byteen = 4'h0; bi0.macroscopic_pc = 32'h3010;
    #1;
    checks++; if (bi0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL irq_fall: got %0h expected 0", bi0.interrupt); end
    cyc(); cyc();
    checks++; if (bi0.interrupt !== 1'b0) begin errors++; $display("[TB] FAIL irq_once: got %0h expected 0", bi0.interrupt); end
    bi0.macroscopic_pc = 32'h0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (bi0.trace_drops !== 16'h0) begin errors++; $display("[TB] FAIL reset_clears_drops: got %0d expected 0", bi0.trace_drops); end
    bi0.macroscopic_pc = 32'h3010;
    bi2.m_data_addr = 32'h4; bi2.m_data_wdata = 32'h55AA55AA; bi2.m_data_byteen = 4'hF;
    for (int i = 0; i < 3; i++) begin
      bi0.m_data_addr = 32'h300 + 32'(4 * i); bi0.m_data_wdata = 32'hA0 + 32'(i);
      bi0.m_data_byteen = 4'hF; bi0.m_inst_addr = 32'h3300 + 32'(4 * i);
      cyc();
      bi0.macroscopic_pc = 32'h0; bi2.m_data_byteen = 4'h0;
    end
    bi0.m_data_byteen = 4'h0; bi0.m_data_addr = 32'h300;
    cyc();
    checks++; if ({bi0.trace_valid, bi0.interrupt} !== 2'b11) begin errors++; $display("[TB] FAIL pre_reset: got valid=%0h irq=%0h expected 1 1", bi0.trace_valid, bi0.interrupt); end
    checks++; if (bi2.m_data_rdata !== 32'h55AA55AA) begin errors++; $display("[TB] FAIL pre_reset_pipe: got %h expected 55AA55AA", bi2.m_data_rdata); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checks++; if ({bi0.trace_valid, bi0.interrupt} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset: got valid=%0h irq=%0h expected 0 0", bi0.trace_valid, bi0.interrupt); end
    checks++; if (bi2.m_data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_pipe: got %h expected 00000000", bi2.m_data_rdata); end
    checks++; if (bi0.m_data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_mem: got %h expected 00000000", bi0.m_data_rdata); end
    bi0.macroscopic_pc = 32'h3010;
    cyc();
    bi0.macroscopic_pc = 32'h0;
    #1;
    checks++; if (bi0.interrupt !== 1'b1) begin errors++; $display("[TB] FAIL irq_refire: got %0h expected 1", bi0.interrupt); end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_range();
    test_latency();
    test_trace_overflow();
    test_irq();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tb_dmem_irq.md
# tb_dmem_irq

Parametrised data-memory and interrupt model for the pipelined MIPS CPU benches. It generalises the fixed 4096-word bench memory with configurable depth, base address and read latency. It also adds out-of-range detection, a buffered write-trace stream with valid/ready handshake, and an interrupt generator that fires at a chosen macroscopic PC and clears on the CPU's acknowledge write. It sits between the `mips` top and the bench's checker, replacing the inline data array and interrupt driving.

## Interface
- `DEPTH_WORDS`, 4096: memory size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; word-aligned.
- `RD_LAT`, 0: read latency in cycles, 0..4.
- `TRACE_DEPTH`, 8: write-trace FIFO entries; power of two, ≥2.
- `IRQ_PC`, 32'h0000_3010: macroscopic PC that triggers the interrupt.
- `IRQ_ADDR`, 32'h0000_7F20: acknowledge address.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `m_data_addr` in 32: CPU data byte address.
- `m_data_wdata` in 32: CPU write data, lane-positioned.
- `m_data_byteen` in 4: byte write enables; 0 means no write.
- `m_inst_addr` in 32: PC of the instruction in M stage.
- `m_data_rdata` out 32: read data.
- `macroscopic_pc` in 32: CPU macroscopic PC.
- `m_int_addr` in 32: interrupt-device write address.
- `m_int_byteen` in 4: interrupt-device byte enables.
- `interrupt` out 1: interrupt request to CPU.
- `oob_err` out 1: one-cycle pulse on an out-of-range write.
- `trace_valid` out 1: trace entry available.
- `trace_ready` in 1: consumer accepts the entry.
- `trace_pc`, `trace_addr`, `trace_data` out 32 each: PC, aligned address, merged word.
- `trace_drops` out 16: saturating count of trace entries lost to a full FIFO.

## Operation
- Word index `idx = (m_data_addr - BASE_ADDR) >> 2`. The access is in range when `m_data_addr >= BASE_ADDR` and `idx < DEPTH_WORDS`.
- Write: occurs when `|m_data_byteen`. The merged word is the current `mem[idx]` with byte lane k replaced by `m_data_wdata[8k+7:8k]` where `byteen[k]` is set. It is stored at the clock edge. The address low 2 bits are ignored.
- Out-of-range write: memory is unchanged, no trace entry is pushed, and `oob_err` is 1 in the following cycle.
- Read: an in-range read returns `mem[idx]`; an out-of-range read returns 0. Reads are read-before-write: a same-cycle write to the same word is not visible.
- `RD_LAT=0`: `m_data_rdata` is combinational. `RD_LAT=N` (N≥1): the address-time read value passes through N register stages.
- Trace FIFO: each in-range write pushes `{m_inst_addr, aligned addr, merged word}`. The FIFO is first-word-fall-through; `trace_valid = !empty`. An entry pops when `trace_valid && trace_ready`.
- FIFO full with a push and no pop: the push is discarded and `trace_drops` increments, saturating at 16'hFFFF.
- FIFO full with a push and a pop in the same cycle: both happen and nothing is dropped. Empty with push and pop: the pop is ignored because `trace_valid` is 0.
- Interrupt FSM, with states ARMED, ASSERTED, DONE:
  - ARMED → ASSERTED when `macroscopic_pc == IRQ_PC`.
  - ASSERTED → DONE when `|m_int_byteen && (m_int_addr & ~3) == IRQ_ADDR`.
  - DONE is terminal until reset.
  - `interrupt` is 1 exactly in ASSERTED. It fires only once per reset.
- An acknowledge write seen while ARMED or DONE is ignored.

## Timing
- Reset state:
  - memory words, pipeline registers and FIFO all cleared;
  - `m_data_rdata` 0 (all stages) for RD_LAT≥1;
  - `interrupt`, `oob_err` and `trace_valid` 0; `trace_drops` 0;
  - FSM in ARMED;
  - all `trace_*` data outputs 0.
- Clearing all of memory on reset is a bulk operation completed in the reset cycle.
- A write is visible to a read issued in the next cycle.
- A trace entry appears on `trace_valid` in the cycle after the write edge.
- `interrupt` rises one cycle after the cycle `macroscopic_pc == IRQ_PC` and falls one cycle after the acknowledge cycle.
- Reset asserted mid-operation overrides everything on that edge: FIFO contents are lost, in-flight read pipeline data is discarded, and the FSM returns to ARMED.

## Test plan
- Write `byteen=4'b0010` to 0x100, data 0xAABBCCDD, over zeroed memory. Then read 0x100 → 0x0000CC00. Trace shows pc, 0x100, 0x0000CC00.
- With `RD_LAT=2`, write 0x12345678 to 0x4, then read 0x4 → data appears 2 cycles after the address. A read at 0x4 in the same cycle as the write returns the old value 0.
- With `DEPTH_WORDS=4096`, write to 0x4000 → `oob_err` pulses for one cycle, no trace entry, and a read of 0x0 is still 0.
- With `TRACE_DEPTH=8`, hold `trace_ready=0` and issue 10 writes → 8 entries retained and `trace_drops=2`. Then drain → entries 1..8 come out in order.
- Drive `macroscopic_pc=IRQ_PC` → `interrupt=1` next cycle and held. Write to 0x7F20 with `m_int_byteen=4'hF` → 0 next cycle. Repeating `IRQ_PC` → no reassertion.
- Assert reset while the FIFO holds 3 entries and `interrupt=1` → next cycle `trace_valid=0`, `interrupt=0`, and `IRQ_PC` refires after reset.
